// File: rtl/eq2_sweeper.sv
// Self-test driver for the 2-bit equality comparator: sweeps every operand pair,
// waits a settle time, samples eq_in and accumulates match/error results.
module eq2_sweeper #(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 eq_in,
  output logic [WIDTH-1:0]     a_out,
  output logic [WIDTH-1:0]     b_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH:0]     match_count,
  output logic [2*WIDTH:0]     err_count,
  output logic [2*WIDTH-1:0]   first_err_idx,
  output logic                 first_err_valid
);

  localparam int IW = 2 * WIDTH;
  localparam int CW = IW + 1;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic [3:0]      r_settleCnt;
  logic            r_busy;
  logic            r_done;
  logic            r_pass;
  logic [CW-1:0]   r_matchCount;
  logic [CW-1:0]   r_errCount;
  logic [IW-1:0]   r_firstErrIdx;
  logic            r_firstErrValid;

  logic            w_expected;
  logic            w_mismatch;
  logic            w_lastVec;
  logic [CW-1:0]   w_matchNext;
  logic [CW-1:0]   w_errNext;

  // Expected result comes from the operands currently presented to the comparator.
  assign w_expected  = (r_idx[IW-1:WIDTH] == r_idx[WIDTH-1:0]);
  assign w_mismatch  = (eq_in != w_expected);
  assign w_lastVec   = &r_idx;
  assign w_matchNext = r_matchCount + CW'(eq_in);
  assign w_errNext   = r_errCount + CW'(w_mismatch);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_idx           <= '0;
      r_settleCnt     <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_pass          <= 1'b0;
      r_matchCount    <= '0;
      r_errCount      <= '0;
      r_firstErrIdx   <= '0;
      r_firstErrValid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state         <= S_SETTLE;
            r_idx           <= '0;
            r_settleCnt     <= '0;
            r_busy          <= 1'b1;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
            r_matchCount    <= '0;
            r_errCount      <= '0;
            r_firstErrIdx   <= '0;
            r_firstErrValid <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (r_settleCnt == SETTLE_LAST) begin
            r_state <= S_SAMPLE;
          end else begin
            r_settleCnt <= r_settleCnt + 4'd1;
          end
        end
        S_SAMPLE: begin
          r_matchCount <= w_matchNext;
          r_errCount   <= w_errNext;
          if (w_mismatch && !r_firstErrValid) begin
            r_firstErrIdx   <= r_idx;
            r_firstErrValid <= 1'b1;
          end
          // Final counts must be visible on the same edge done rises.
          if (w_lastVec) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_errNext == '0);
          end else begin
            r_state     <= S_SETTLE;
            r_idx       <= r_idx + IW'(1);
            r_settleCnt <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign a_out           = r_idx[IW-1:WIDTH];
  assign b_out           = r_idx[WIDTH-1:0];
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign match_count     = r_matchCount;
  assign err_count       = r_errCount;
  assign first_err_idx   = r_firstErrIdx;
  assign first_err_valid = r_firstErrValid;

endmodule

// File: tb/tb_eq2_sweeper.sv
// Bench for eq2_sweeper: a fault-mask comparator model drives eq_in, and sweep
// results are compared against a table of expected outcomes.
module tb_eq2_sweeper;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start0, start1;
  logic        eq0, eq1;
  logic [15:0] mask0, mask1;
  logic [1:0]  a0, b0, a1, b1;
  logic        busy0, done0, pass0, fv0, busy1, done1, pass1, fv1;
  logic [4:0]  match0, err0, match1, err1;
  logic [3:0]  first0, first1;

  eq2_sweeper dut0 (
    .clk(clk), .rst(rst), .start(start0), .eq_in(eq0),
    .a_out(a0), .b_out(b0), .busy(busy0), .done(done0), .pass(pass0),
    .match_count(match0), .err_count(err0),
    .first_err_idx(first0), .first_err_valid(fv0)
  );

  eq2_sweeper #(.WIDTH(2), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .eq_in(eq1),
    .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1),
    .match_count(match1), .err_count(err1),
    .first_err_idx(first1), .first_err_valid(fv1)
  );

  // Comparator under test: ideal equality, with a set mask bit flipping that pair's answer.
  always_comb begin
    eq0 = (a0 == b0) ^ mask0[{a0, b0}];
    eq1 = (a1 == b1) ^ mask1[{a1, b1}];
  end

  int sel;
  logic [1:0] aS, bS;
  logic       busyS, doneS, passS, fvS;
  logic [4:0] matchS, errS;
  logic [3:0] firstS;

  always_comb begin
    aS     = (sel == 0) ? a0 : a1;
    bS     = (sel == 0) ? b0 : b1;
    busyS  = (sel == 0) ? busy0 : busy1;
    doneS  = (sel == 0) ? done0 : done1;
    passS  = (sel == 0) ? pass0 : pass1;
    fvS    = (sel == 0) ? fv0 : fv1;
    matchS = (sel == 0) ? match0 : match1;
    errS   = (sel == 0) ? err0 : err1;
    firstS = (sel == 0) ? first0 : first1;
  end

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    string       name;
    int          sel;
    logic [15:0] mask;
    int          pulseAt;
    int          expBusy;
    int          expMatch;
    int          expErr;
    int          expFirst;
    int          expFirstValid;
    int          expPass;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Whole-sweep outcome derived directly from the fault mask.
  function automatic void refModel(input logic [15:0] mask, output int m, output int e,
                                   output int f, output int fv);
    bit ideal;
    bit eq;
    m = 0; e = 0; f = 0; fv = 0;
    for (int i = 0; i < 16; i++) begin
      ideal = ((i / 4) == (i % 4));
      eq    = ideal ^ mask[i];
      if (eq) m++;
      if (mask[i]) begin
        e++;
        if (fv == 0) begin
          f  = i;
          fv = 1;
        end
      end
    end
  endfunction

  function automatic logic [15:0] stuckMask(input bit v);
    logic [15:0] m;
    for (int i = 0; i < 16; i++) m[i] = (((i / 4) == (i % 4)) != v);
    return m;
  endfunction

  function automatic vec_t mkVec(input string name, input int s, input logic [15:0] mask,
                                 input int pulseAt, input int m, input int e, input int f,
                                 input int fv, input int p);
    vec_t v;
    v.name = name; v.sel = s; v.mask = mask; v.pulseAt = pulseAt;
    v.expBusy = 16 * ((s == 0) ? 3 : 2);
    v.expMatch = m; v.expErr = e; v.expFirst = f; v.expFirstValid = fv; v.expPass = p;
    return v;
  endfunction

  task automatic setStart(input logic v);
    if (sel == 0) start0 = v;
    else start1 = v;
  endtask

  task automatic applyStimulus(input logic [15:0] mask, input int pulseAt,
                               output int busyCycles, output int opBad);
    int per;
    per = (sel == 0) ? 3 : 2;
    if (sel == 0) mask0 = mask;
    else mask1 = mask;
    setStart(1'b1);
    @(posedge clk); #1;
    setStart(1'b0);
    checkOutput("startBusy", 32'(busyS), 1);
    checkOutput("startOperands", 32'({aS, bS}), 0);
    checkOutput("startClearMatch", 32'(matchS), 0);
    checkOutput("startClearErr", 32'(errS), 0);
    checkOutput("startClearFirstValid", 32'(fvS), 0);
    busyCycles = 0;
    opBad = 0;
    for (int k = 0; k < 2000; k++) begin
      if (!busyS) break;
      if (int'({aS, bS}) != k / per) opBad++;
      busyCycles++;
      if (k == pulseAt) setStart(1'b1);
      @(posedge clk); #1;
      if (k == pulseAt) setStart(1'b0);
    end
    checkOutput("sweepEnded", 32'(busyS), 0);
    checkOutput("doneAfterSweep", 32'(doneS), 1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".a"}, 32'(a0), 0);
    checkOutput({tag, ".b"}, 32'(b0), 0);
    checkOutput({tag, ".busy"}, 32'(busy0), 0);
    checkOutput({tag, ".done"}, 32'(done0), 0);
    checkOutput({tag, ".pass"}, 32'(pass0), 0);
    checkOutput({tag, ".match"}, 32'(match0), 0);
    checkOutput({tag, ".err"}, 32'(err0), 0);
    checkOutput({tag, ".firstIdx"}, 32'(first0), 0);
    checkOutput({tag, ".firstValid"}, 32'(fv0), 0);
  endtask

  initial begin
    int busyCycles, opBad;
    int m, e, f, fv;
    logic [15:0] rmask;

    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    mask0 = '0; mask1 = '0; sel = 0;
    #12;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b0;

    vecs.push_back(mkVec("ideal", 0, 16'h0000, -1, 4, 0, 0, 0, 1));
    vecs.push_back(mkVec("ideal.startAt10", 0, 16'h0000, 10, 4, 0, 0, 0, 1));
    vecs.push_back(mkVec("stuck1", 0, stuckMask(1'b1), -1, 16, 12, 1, 1, 0));
    vecs.push_back(mkVec("reconnect", 0, 16'h0000, -1, 4, 0, 0, 0, 1));
    vecs.push_back(mkVec("stuck0", 0, stuckMask(1'b0), -1, 0, 4, 0, 1, 0));
    for (int r = 0; r < 4; r++) begin
      rmask = 16'($urandom);
      if (r == 0) rmask = 16'h8000;
      refModel(rmask, m, e, f, fv);
      vecs.push_back(mkVec($sformatf("rand%0d", r), 0, rmask, -1, m, e, f, fv, (e == 0) ? 1 : 0));
    end
    vecs.push_back(mkVec("settle1.ideal", 1, 16'h0000, -1, 4, 0, 0, 0, 1));
    rmask = 16'($urandom);
    refModel(rmask, m, e, f, fv);
    vecs.push_back(mkVec("settle1.rand", 1, rmask, -1, m, e, f, fv, (e == 0) ? 1 : 0));

    foreach (vecs[n]) begin
      sel = vecs[n].sel;
      applyStimulus(vecs[n].mask, vecs[n].pulseAt, busyCycles, opBad);
      checkOutput({vecs[n].name, ".busyCycles"}, busyCycles, vecs[n].expBusy);
      checkOutput({vecs[n].name, ".operandSeq"}, opBad, 0);
      checkOutput({vecs[n].name, ".match"}, 32'(matchS), vecs[n].expMatch);
      checkOutput({vecs[n].name, ".err"}, 32'(errS), vecs[n].expErr);
      checkOutput({vecs[n].name, ".firstIdx"}, 32'(firstS), vecs[n].expFirst);
      checkOutput({vecs[n].name, ".firstValid"}, 32'(fvS), vecs[n].expFirstValid);
      checkOutput({vecs[n].name, ".pass"}, 32'(passS), vecs[n].expPass);
    end

    // Reset in the middle of a sweep, once the operand pair reaches index 7.
    sel = 0;
    mask0 = 16'h0000;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if ({a0, b0} == 4'd7) break;
      @(posedge clk); #1;
    end
    checkOutput("rst.reachIdx7", 32'({a0, b0}), 7);
    rst = 1'b1;
    #1;
    checkAllZero("rst.immediate");
    @(posedge clk); #1;
    checkOutput("rst.heldBusy", 32'(busy0), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst.idleAfter", 32'(busy0), 0);
    applyStimulus(16'h0000, -1, busyCycles, opBad);
    checkOutput("rst.sweep.busyCycles", busyCycles, 48);
    checkOutput("rst.sweep.operandSeq", opBad, 0);
    checkOutput("rst.sweep.match", 32'(match0), 4);
    checkOutput("rst.sweep.err", 32'(err0), 0);
    checkOutput("rst.sweep.pass", 32'(pass0), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/eq2_sweeper.md
# eq2_sweeper

Self-test driver for the 2-bit equality comparator. On `start` it drives every operand pair onto the comparator's `a`/`b` inputs in turn and waits a programmable settle time. It then samples the comparator's equality output and checks it against the expected result. It reports match and error counts, the first failing vector, and a pass/fail flag for the board LEDs. It sits on the driving side of the comparator's operand/result interface.

## Interface
- `WIDTH`, default 2, operand width per bus. Operand pairs swept: 2^(2·WIDTH).
- `SETTLE`, default 2, cycles operands are held before sampling. Legal range 1..15.
- `clk`  in  1  single system clock. All state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begins a sweep. Sampled only in IDLE or DONE.
- `eq_in`  in  1  equality result returned by the comparator under test.
- `a_out`  out  WIDTH  operand A to comparator.
- `b_out`  out  WIDTH  operand B to comparator.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  high in DONE until the next start or reset.
- `pass`  out  1  valid when `done`=1. High iff `err_count`==0.
- `match_count`  out  2·WIDTH+1  number of samples with `eq_in`=1.
- `err_count`  out  2·WIDTH+1  number of samples where `eq_in` ≠ (`a_out`==`b_out`).
- `first_err_idx`  out  2·WIDTH  vector index of the first mismatch.
- `first_err_valid`  out  1  high once a mismatch has been captured.

## Operation
- Internal vector index `idx`, width 2·WIDTH.
  - `a_out` = `idx`[2W-1:W], `b_out` = `idx`[W-1:0], both registered directly from `idx`.
- States:
  - IDLE:
    - Outputs at reset values.
    - `start`=1 → clear all counters and capture regs, `idx`=0, settle counter=0, go to SETTLE.
  - SETTLE:
    - Settle counter increments each cycle.
    - When it reaches SETTLE-1 → go to SAMPLE.
  - SAMPLE (one cycle):
    - At the exiting edge, compute expected = (`a_out`==`b_out`).
    - If `eq_in`=1, increment `match_count`.
    - If `eq_in` ≠ expected, increment `err_count`. If `first_err_valid`=0, also load `first_err_idx`=`idx` and set `first_err_valid`.
    - If `idx` = all-ones → go to DONE.
    - Otherwise `idx`+1, settle counter=0, go to SETTLE.
  - DONE:
    - `done`=1, `pass`=(`err_count`==0). All result outputs hold.
    - `start`=1 → same action as from IDLE: clear everything and restart at `idx`=0.
- `busy`=1 exactly in SETTLE and SAMPLE.
- `start` asserted in SETTLE or SAMPLE is ignored. No queuing.
- Counters cannot overflow: their maximum value 2^(2W) fits in 2W+1 bits.
- `idx` never wraps inside a sweep. The sweep ends at the all-ones vector.
- `eq_in` is treated as synchronous to `clk`; it is driven combinationally from `a_out`/`b_out`. No internal synchronizer.

## Timing
- Reset values (asynchronous, immediate on `rst`=1):
  - All outputs 0: `a_out`, `b_out`, `busy`, `done`, `pass`, both counts, `first_err_idx`, `first_err_valid`.
  - State = IDLE.
- Reset mid-sweep aborts the sweep. No partial results are retained.
- Start to busy: `start` high at edge N → `busy`=1 and `a_out`=`b_out`=0 from edge N.
- Per vector: SETTLE cycles in SETTLE plus one cycle in SAMPLE, so SETTLE+1 cycles per vector.
  - `eq_in` is sampled at the SAMPLE exit edge, which is SETTLE+1 edges after the operands change.
- Total `busy` time: 2^(2W)·(SETTLE+1) cycles. Defaults: 16·3 = 48 cycles.
- `done` rises on the same edge that `busy` falls. Final counts are visible that same cycle.
- `start` held high continuously in DONE restarts a sweep on every DONE entry. This is the intended free-run mode.

## Test plan
- Ideal comparator model on `eq_in`, defaults, `start` pulse:
  - `busy` high exactly 48 cycles, then `done`=1.
  - `match_count`=4, `err_count`=0, `pass`=1, `first_err_valid`=0.
- `eq_in` stuck at 1:
  - `match_count`=16, `err_count`=12, `pass`=0.
  - `first_err_idx`=1 (a=0, b=1), `first_err_valid`=1.
- `eq_in` stuck at 0:
  - `match_count`=0, `err_count`=4, `first_err_idx`=0, `pass`=0.
- `start` pulsed again at cycle 10 of a sweep:
  - Ignored. Sweep still ends at cycle 48 with results identical to the first scenario.
- `rst` asserted while `idx`=7:
  - All outputs 0 immediately, state IDLE.
  - A new `start` produces a full 48-cycle sweep with correct counts.
- From DONE after the stuck-at-1 run, reconnect the ideal model and pulse `start`:
  - Counts and `first_err_valid` clear on the start edge.
  - Final `pass`=1, `err_count`=0.
- Parameter variant SETTLE=1:
  - `busy` lasts 32 cycles.
  - `eq_in` sampled 2 edges after each operand change.
  - Ideal-model result identical to the first scenario.
